// File: rtl/mem_data_ram_io.sv
// RV32E data memory: big-endian heap RAM behind memory-mapped synchronised inputs,
// output registers and a W1C change-flag status word, with a post-reset heap clear.

module mem_data_ram_io_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_async,
  output logic [7:0] o_sync,
  output logic       o_chg
);
  logic [SYNC_STAGES-1:0][7:0] r_pipe;
  logic [7:0]                  r_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pipe <= '0;
      r_prev <= '0;
    end else begin
      r_pipe <= {r_pipe[SYNC_STAGES-2:0], i_async};
      r_prev <= r_pipe[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_pipe[SYNC_STAGES-1];
  assign o_chg  = |(o_sync ^ r_prev);
endmodule

module mem_data_ram_io #(
  parameter int DEPTH_BYTES = 128,
  parameter int NUM_IN      = 2,
  parameter int NUM_OUT     = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          addr_bus,
  input  logic [1:0]           size,
  input  logic [31:0]          write_data_bus,
  input  logic                 write_signal,
  output logic [31:0]          read_data_bus,
  output logic                 busy,
  output logic                 fault,
  output logic                 irq,
  input  logic [8*NUM_IN-1:0]  i,
  output logic [8*NUM_OUT-1:0] o
);
  localparam int STAT       = 4*(NUM_IN+NUM_OUT);
  localparam int HEAP_BASE  = STAT + 4;
  localparam int HEAP_BYTES = DEPTH_BYTES - HEAP_BASE;
  localparam int CLR_CYC    = HEAP_BYTES / 4;
  localparam int PW         = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
  localparam int HW         = PW + 2;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  r_state;
  logic                    r_busy, r_fault, r_irq;
  logic [PW-1:0]           r_ptr;
  logic [NUM_IN-1:0]       r_flags, r_irq_en, w_chg, w_clr;
  logic [NUM_OUT-1:0][7:0] r_out;
  logic [NUM_IN-1:0][7:0]  w_in;
  logic [7:0]              r_mem [HEAP_BYTES];

  for (genvar k = 0; k < NUM_IN; k++) begin : g_in
    mem_data_ram_io_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .reset  (reset),
      .i_async(i[8*k +: 8]),
      .o_sync (w_in[k]),
      .o_chg  (w_chg[k])
    );
  end

  // Store data is left-aligned so lane j always carries the byte for addr+j.
  logic [2:0]  w_nbytes;
  logic        w_align;
  logic [31:0] w_wd_al;
  always_comb begin
    w_nbytes = '0;
    w_align  = 1'b0;
    w_wd_al  = '0;
    case (size)
      2'b00: begin w_nbytes = 3'd1; w_align = 1'b1;                 w_wd_al = {write_data_bus[7:0], 24'd0};  end
      2'b01: begin w_nbytes = 3'd2; w_align = !addr_bus[0];         w_wd_al = {write_data_bus[15:0], 16'd0}; end
      2'b10: begin w_nbytes = 3'd4; w_align = (addr_bus[1:0] == 2'b00); w_wd_al = write_data_bus;             end
      default: ;
    endcase
  end

  logic [32:0] w_end;
  logic        w_in_range, w_legal, w_ready, w_wr_ok;
  assign w_end      = {1'b0, addr_bus} + {30'd0, w_nbytes};
  assign w_in_range = (w_end <= 33'(DEPTH_BYTES));
  assign w_legal    = w_align && w_in_range && (addr_bus >= 32'(4*NUM_IN));
  assign w_ready    = (r_state == READY);
  assign w_wr_ok    = write_signal && w_ready && w_legal;

  logic [3:0][31:0]   w_wa;
  logic [3:0][7:0]    w_wb, w_rb;
  logic [3:0][HW-1:0] w_hidx;
  logic [3:0]         w_we;
  for (genvar j = 0; j < 4; j++) begin : g_lane
    assign w_wa[j]   = addr_bus + 32'(j);
    assign w_wb[j]   = w_wd_al[31-8*j -: 8];
    assign w_hidx[j] = HW'(w_wa[j] - 32'(HEAP_BASE));
    assign w_we[j]   = w_wr_ok && (3'(j) < w_nbytes);
  end

  always_comb begin
    w_rb          = '0;
    w_clr         = '0;
    read_data_bus = '0;
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < NUM_IN; k++)
        if (w_wa[j] == 32'(4*k+3)) w_rb[j] = w_in[k];
      for (int k = 0; k < NUM_OUT; k++)
        if (w_wa[j] == 32'(4*(NUM_IN+k)+3)) w_rb[j] = r_out[k];
      if (w_wa[j] == 32'(STAT+2)) w_rb[j] = 8'(r_irq_en);
      if (w_wa[j] == 32'(STAT+3)) w_rb[j] = 8'(r_flags);
      if (w_wa[j] >= 32'(HEAP_BASE) && w_wa[j] < 32'(DEPTH_BYTES)) w_rb[j] = r_mem[w_hidx[j]];
      if (w_we[j] && w_wa[j] == 32'(STAT+3)) w_clr = w_wb[j][NUM_IN-1:0];
    end
    if (w_ready && w_align && w_in_range)
      for (int j = 0; j < 4; j++)
        if (3'(j) < w_nbytes) read_data_bus = {read_data_bus[23:0], w_rb[j]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= CLEAR;
      r_busy   <= 1'b1;
      r_ptr    <= '0;
      r_fault  <= 1'b0;
      r_irq    <= 1'b0;
      r_flags  <= '0;
      r_irq_en <= '0;
      r_out    <= '0;
    end else begin
      r_fault <= write_signal && w_ready && !w_legal;
      r_irq   <= |(r_flags & r_irq_en);
      // Set is OR'd in after the clear so a coincident change survives.
      r_flags <= (r_flags & ~w_clr) | w_chg;
      case (r_state)
        CLEAR: begin
          r_ptr <= r_ptr + PW'(1);
          if (r_ptr == PW'(CLR_CYC-1)) begin
            r_state <= READY;
            r_busy  <= 1'b0;
          end
        end
        READY: begin
          for (int j = 0; j < 4; j++) begin
            if (w_we[j]) begin
              for (int k = 0; k < NUM_OUT; k++)
                if (w_wa[j] == 32'(4*(NUM_IN+k)+3)) r_out[k] <= w_wb[j];
              if (w_wa[j] == 32'(STAT+2)) r_irq_en <= w_wb[j][NUM_IN-1:0];
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == CLEAR) begin
      for (int b = 0; b < 4; b++) r_mem[{r_ptr, 2'(b)}] <= '0;
    end else begin
      for (int j = 0; j < 4; j++)
        if (w_we[j] && w_wa[j] >= 32'(HEAP_BASE)) r_mem[w_hidx[j]] <= w_wb[j];
    end
  end

  assign busy  = r_busy;
  assign fault = r_fault;
  assign irq   = r_irq;
  assign o     = r_out;
endmodule
